id_hazard_scoreboard: RTL
=========================

Name: id_hazard_scoreboard

Overview:
- Parametrised load-use hazard tracker for the decode stage.
- Replaces the two fixed load_related_1/load_related_2 inputs with an internal scoreboard.
- Tracks destination registers of in-flight loads over LOAD_DEPTH pipeline slots.
- Compares them against NUM_READ_PORTS decode read channels and raises the decode stall request and per-channel related flags.

Parameters:
NUM_READ_PORTS, 2, number of register read channels checked per decoded instruction
REG_ADDR_WIDTH, 5, register address width
LOAD_DEPTH, 2, cycles after issue before load data can be forwarded (slot count, >=1)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
stall_in  input  1  downstream pipeline stall; freezes scoreboard
flush  input  1  pipeline flush; clears all pending entries
issue_valid  input  1  decode holds a valid instruction this cycle
issue_write_en  input  1  instruction writes a register
issue_write_addr  input  REG_ADDR_WIDTH  destination register
issue_is_load  input  1  instruction is a memory load
read_en  input  NUM_READ_PORTS  per-channel read enable
read_addr  input  NUM_READ_PORTS*REG_ADDR_WIDTH  channel k at bits [k*W +: W]
related  output  NUM_READ_PORTS  channel k depends on a pending load
stall_request  output  1  OR of related; decode must hold
pending_count  output  $clog2(LOAD_DEPTH+1)  number of valid slots

Behaviour:
- State: LOAD_DEPTH slots {valid, addr}. Slot 0 is youngest. Slot LOAD_DEPTH-1 retires on the next shift.
- Reset (async, rst=1): all slot valid bits cleared. Consequently related=0, stall_request=0, pending_count=0 while in reset and immediately after.
- related[k] (combinational, same cycle):
  - read_en[k] && read_addr[k]!=0 && some slot i has valid && addr==read_addr[k].
  - Register 0 never produces a hazard.
- stall_request = |related, combinational, no added latency.
- Accept = issue_valid && issue_write_en && issue_is_load && issue_write_addr!=0 && !stall_request.
- Rising edge, priority order:
  1. flush=1: all slots invalid. Flush wins over stall_in and accept.
  2. else stall_in=1: all slots hold; no accept.
  3. else shift:
     - slot[i] <= slot[i-1] for i>=1; the oldest entry drops out.
     - slot[0] <= {Accept, issue_write_addr}. A rejected or non-load issue inserts a bubble (valid=0).
- Self-stall inserts a bubble while older entries advance, so a dependent instruction stalls exactly until its producer leaves slot LOAD_DEPTH-1.
- A consumer issued d cycles after the load (d>=1) stalls max(0, LOAD_DEPTH-d+1) cycles.
- Duplicate addresses in multiple slots are legal (e.g. back-to-back loads to the same register). A match on any of them stalls.
- Several channels matching the same or different slots: each related bit is set independently.
- pending_count is a popcount of the valid bits, combinational from registered state.
- Reset asserted mid-stall clears everything asynchronously. The stall drops in the same cycle.

Optional Feature:
SCOREBOARD_PERF_EN:
- When defined, add output stall_cycles [31:0]:
  - Async-reset to 0.
  - Increments on each rising edge with stall_request=1 and stall_in=0 and flush=0.
  - Saturates at 32'hFFFF_FFFF.
- When undefined, the port and counter are absent. All other behaviour is identical.

Test Plan:
- Defaults. Issue lw r5 (accepted at edge 0), then a consumer reading r5 on channel 0 from cycle 1 → related=2'b01, stall_request=1 in cycles 1 and 2, 0 in cycle 3. pending_count goes 1,1,0.
- Issue lw r5, one unrelated instruction, then a consumer reading r5 → exactly 1 stall cycle. Consumer three cycles after the load → 0 stall cycles.
- lw r0, then read r0 on both channels → no stall, pending_count=0. Non-load write to r7, then read r7 → no stall.
- lw r9, then stall_in=1 for 3 cycles while a consumer reads r9 → stall_request stays 1 and slot state is frozen. After stall_in drops, 2 more stall cycles occur (LOAD_DEPTH=2).
- lw r4, then flush=1 together with stall_in=1 → next cycle pending_count=0 and reading r4 gives no stall. Assert rst mid-stall → stall_request=0 immediately.
- LOAD_DEPTH=4, NUM_READ_PORTS=3: lw r3, then a consumer reading r3 on channels 0 and 2 → related=3'b101 for 4 cycles. With SCOREBOARD_PERF_EN, stall_cycles=4 afterwards.

Source files
------------

// File: rtl/id_hazard_scoreboard.sv
// id_hazard_scoreboard
//   Load-use hazard tracker for the decode stage. It keeps the destination
//   registers of in-flight loads in a LOAD_DEPTH-deep shift scoreboard.
//   Every decode read channel is compared against all valid slots. A match
//   raises that channel's related flag and the decode stall request.
//
// Optional feature (macro SCOREBOARD_PERF_EN): adds the stall_cycles output.
//   It is a saturating count of the rising edges on which decode was held
//   by a load-use hazard. The edge is not counted when stall_in or flush
//   is also active.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   stall_in          downstream stall, freezes the scoreboard
//   flush             clears all pending entries (wins over stall_in)
//   issue_*           instruction currently in decode
//   read_en/read_addr per-channel source operands, channel k at [k*W +: W]
//   related           per-channel dependency on a pending load
//   stall_request     OR of related
//   pending_count     number of valid scoreboard slots
//   stall_cycles      (SCOREBOARD_PERF_EN only) hazard stall cycle counter
module id_hazard_scoreboard #(
  parameter int NUM_READ_PORTS = 2,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int LOAD_DEPTH     = 2,
  localparam int CNT_W         = $clog2(LOAD_DEPTH + 1)
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     stall_in,
  input  logic                                     flush,
  input  logic                                     issue_valid,
  input  logic                                     issue_write_en,
  input  logic [REG_ADDR_WIDTH-1:0]                issue_write_addr,
  input  logic                                     issue_is_load,
  input  logic [NUM_READ_PORTS-1:0]                read_en,
  input  logic [NUM_READ_PORTS*REG_ADDR_WIDTH-1:0] read_addr,
  output logic [NUM_READ_PORTS-1:0]                related,
  output logic                                     stall_request,
  output logic [CNT_W-1:0]                         pending_count
`ifdef SCOREBOARD_PERF_EN
  ,
  output logic [31:0]                              stall_cycles
`endif
);

  // Slot 0 is the youngest entry; slot LOAD_DEPTH-1 retires on the next shift.
  logic [LOAD_DEPTH-1:0]     valid_q, valid_d;
  logic [REG_ADDR_WIDTH-1:0] addr_q [LOAD_DEPTH];
  logic [REG_ADDR_WIDTH-1:0] addr_d [LOAD_DEPTH];
  logic                      accept;

  always_comb begin
    related = '0;
    for (int k = 0; k < NUM_READ_PORTS; k++) begin
      for (int i = 0; i < LOAD_DEPTH; i++) begin
        if (read_en[k] && (read_addr[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] != '0) &&
            valid_q[i] && (addr_q[i] == read_addr[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]))
          related[k] = 1'b1;
      end
    end
  end

  assign stall_request = |related;

  always_comb begin
    pending_count = '0;
    for (int i = 0; i < LOAD_DEPTH; i++)
      pending_count = pending_count + CNT_W'(valid_q[i]);
  end

  // A load that is itself stalled must not enter the scoreboard. It is
  // re-presented by decode once its own hazard clears.
  assign accept = issue_valid && issue_write_en && issue_is_load &&
                  (issue_write_addr != '0) && !stall_request;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    if (flush) begin
      valid_d = '0;
    end else if (!stall_in) begin
      for (int i = LOAD_DEPTH - 1; i >= 1; i--) begin
        valid_d[i] = valid_q[i-1];
        addr_d[i]  = addr_q[i-1];
      end
      valid_d[0] = accept;
      addr_d[0]  = issue_write_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < LOAD_DEPTH; i++)
        addr_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
    end
  end

`ifdef SCOREBOARD_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_request && !stall_in && !flush && (stall_cycles_q != 32'hFFFF_FFFF))
      stall_cycles_d = stall_cycles_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cycles_q <= '0;
    else     stall_cycles_q <= stall_cycles_d;
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule
